// File: rtl/reg_display_pkg.sv
// rtl/reg_display_pkg.sv - shared types, constants and segment decode for reg_display_ctrl
package reg_display_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_CONV_A,
    ST_CONV_B,
    ST_UPDATE
  } state_t;

  localparam int OVF_LIMIT  = 100;
  localparam int CONV_STEPS = 7;

  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  // Non-decimal nibbles cannot occur for in-range values; blank them defensively.
  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    if (digit <= 4'd9) return SEG_DIGIT[digit];
    return SEG_BLANK;
  endfunction

  function automatic logic [6:0] seg_tens(input logic ovf, input logic [3:0] tens,
                                          input logic blank_zero);
    if (ovf) return SEG_DASH;
    if (blank_zero && tens == 4'd0) return SEG_BLANK;
    return seg_decode(tens);
  endfunction

  function automatic logic [6:0] seg_units(input logic ovf, input logic [3:0] units);
    if (ovf) return SEG_DASH;
    return seg_decode(units);
  endfunction

endpackage

// File: rtl/bcd_dabble_unit.sv
// rtl/bcd_dabble_unit.sv - iterative 7-bit binary to two-digit BCD converter
module bcd_dabble_unit
  import reg_display_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [6:0] value,
  input  logic       step,
  output logic       done,
  output logic [3:0] tens,
  output logic [3:0] units
);

  logic [14:0] shreg;
  logic [14:0] adj;
  logic [14:0] nxt;
  logic [2:0]  cnt;

  always_comb begin
    adj = shreg;
    if (shreg[14:11] >= 4'd5) adj[14:11] = shreg[14:11] + 4'd3;
    if (shreg[10:7]  >= 4'd5) adj[10:7]  = shreg[10:7]  + 4'd3;
    nxt = adj << 1;
  end

  // Digits are taken from the post-step value so the caller can latch them on the final step edge.
  assign tens  = nxt[14:11];
  assign units = nxt[10:7];
  assign done  = step && (cnt == 3'(CONV_STEPS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (load) begin
      shreg <= {8'd0, value};
      cnt   <= '0;
    end else if (step) begin
      shreg <= nxt;
      cnt   <= cnt + 3'd1;
    end
  end

endmodule

// File: rtl/reg_display_ctrl.sv
// rtl/reg_display_ctrl.sv - periodic two-channel register snapshot to seven-segment display
module reg_display_ctrl
  import reg_display_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REFRESH_CYCLES = 500000,
  parameter int BLANK_LEADING  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] rf_a_val,
  input  logic [DATA_WIDTH-1:0] rf_b_val,
  input  logic                  force_update,
  output logic [6:0]            hex7,
  output logic [6:0]            hex6,
  output logic [6:0]            hex5,
  output logic [6:0]            hex4,
  output logic                  a_ovf,
  output logic                  b_ovf,
  output logic                  busy,
  output logic                  update_done
);

  localparam int CNT_W = $clog2(REFRESH_CYCLES);

  logic [CNT_W-1:0]      refresh_cnt;
  logic                  tick;
  state_t                state;
  logic [DATA_WIDTH-1:0] snap_a, snap_b;
  logic                  ovf_a_q, ovf_b_q;
  logic [3:0]            a_tens, a_units, b_tens, b_units;

  logic       conv_load, conv_step, conv_done;
  logic [6:0] conv_value;
  logic [3:0] conv_tens, conv_units;

  assign tick = (refresh_cnt == CNT_W'(REFRESH_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || tick) refresh_cnt <= '0;
    else             refresh_cnt <= refresh_cnt + 1'b1;
  end

  // The converter is reloaded with channel B on the same edge that finishes channel A.
  assign conv_step  = (state == ST_CONV_A) || (state == ST_CONV_B);
  assign conv_load  = (state == ST_CAPTURE) || ((state == ST_CONV_A) && conv_done);
  assign conv_value = (state == ST_CAPTURE) ? snap_a[6:0] : snap_b[6:0];

  bcd_dabble_unit u_dabble (
    .clk   (clk),
    .rst   (rst),
    .load  (conv_load),
    .value (conv_value),
    .step  (conv_step),
    .done  (conv_done),
    .tens  (conv_tens),
    .units (conv_units)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      snap_a      <= '0;
      snap_b      <= '0;
      ovf_a_q     <= 1'b0;
      ovf_b_q     <= 1'b0;
      a_tens      <= '0;
      a_units     <= '0;
      b_tens      <= '0;
      b_units     <= '0;
      hex7        <= SEG_BLANK;
      hex6        <= SEG_BLANK;
      hex5        <= SEG_BLANK;
      hex4        <= SEG_BLANK;
      a_ovf       <= 1'b0;
      b_ovf       <= 1'b0;
      busy        <= 1'b0;
      update_done <= 1'b0;
    end else begin
      update_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (tick || force_update) begin
            snap_a <= rf_a_val;
            snap_b <= rf_b_val;
            busy   <= 1'b1;
            state  <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          ovf_a_q <= (snap_a >= DATA_WIDTH'(OVF_LIMIT));
          ovf_b_q <= (snap_b >= DATA_WIDTH'(OVF_LIMIT));
          state   <= ST_CONV_A;
        end
        ST_CONV_A: begin
          if (conv_done) begin
            a_tens  <= conv_tens;
            a_units <= conv_units;
            state   <= ST_CONV_B;
          end
        end
        ST_CONV_B: begin
          if (conv_done) begin
            b_tens  <= conv_tens;
            b_units <= conv_units;
            state   <= ST_UPDATE;
          end
        end
        ST_UPDATE: begin
          hex7        <= seg_tens(ovf_a_q, a_tens, BLANK_LEADING != 0);
          hex6        <= seg_units(ovf_a_q, a_units);
          hex5        <= seg_tens(ovf_b_q, b_tens, BLANK_LEADING != 0);
          hex4        <= seg_units(ovf_b_q, b_units);
          a_ovf       <= ovf_a_q;
          b_ovf       <= ovf_b_q;
          update_done <= 1'b1;
          busy        <= 1'b0;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_display_ctrl.sv
// tb/tb_reg_display_ctrl.sv - scoreboard bench for reg_display_ctrl
module tb_reg_display_ctrl;

  typedef struct packed {
    logic [6:0] h7;
    logic [6:0] h6;
    logic [6:0] h5;
    logic [6:0] h4;
    logic       ao;
    logic       bo;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [31:0] rf_a_val;
  logic [31:0] rf_b_val;
  logic        force_update;
  logic [6:0]  hex7, hex6, hex5, hex4;
  logic        a_ovf, b_ovf, busy, update_done;

  logic        ar_force;
  logic [6:0]  ar_hex7, ar_hex6, ar_hex5, ar_hex4;
  logic        ar_a_ovf, ar_b_ovf, ar_busy, ar_update_done;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];

  reg_display_ctrl dut (
    .clk(clk), .rst(rst), .rf_a_val(rf_a_val), .rf_b_val(rf_b_val),
    .force_update(force_update), .hex7(hex7), .hex6(hex6), .hex5(hex5), .hex4(hex4),
    .a_ovf(a_ovf), .b_ovf(b_ovf), .busy(busy), .update_done(update_done)
  );

  reg_display_ctrl #(.DATA_WIDTH(32), .REFRESH_CYCLES(20), .BLANK_LEADING(0)) dut_ar (
    .clk(clk), .rst(rst), .rf_a_val(rf_a_val), .rf_b_val(rf_b_val),
    .force_update(ar_force), .hex7(ar_hex7), .hex6(ar_hex6), .hex5(ar_hex5), .hex4(ar_hex4),
    .a_ovf(ar_a_ovf), .b_ovf(ar_b_ovf), .busy(ar_busy), .update_done(ar_update_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [6:0] m_seg(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'bxxxxxxx;
    endcase
  endfunction

  function automatic logic [14:0] chan_model(input logic [31:0] v, input bit blank);
    int unsigned vi;
    logic [6:0] t;
    vi = v;
    if (vi >= 100) return {7'b0111111, 7'b0111111, 1'b1};
    t = (blank && vi / 10 == 0) ? 7'b1111111 : m_seg(int'(vi / 10));
    return {t, m_seg(int'(vi % 10)), 1'b0};
  endfunction

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input bit blank);
    logic [14:0] ca, cb;
    ca = chan_model(a, blank);
    cb = chan_model(b, blank);
    return {ca[14:1], cb[14:1], ca[0], cb[0]};
  endfunction

  always @(negedge clk) begin
    if (update_done === 1'b1) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_update got %h required no update", {hex7, hex6, hex5, hex4, a_ovf, b_ovf});
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        if ({hex7, hex6, hex5, hex4, a_ovf, b_ovf} !== e) begin
          n_fail++;
          $display("FAIL display_values got %h required %h", {hex7, hex6, hex5, hex4, a_ovf, b_ovf}, e);
        end
      end
    end
  end

  task automatic test_reset();
    logic [31:0] snap;
    int changed;
    rst = 1'b1; force_update = 1'b0; ar_force = 1'b0;
    rf_a_val = '0; rf_b_val = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({hex7, hex6, hex5, hex4, a_ovf, b_ovf, busy, update_done} !== {28'hFFFFFFF, 4'b0000}) begin
      n_fail++;
      $display("FAIL reset_state got %h required %h",
               {hex7, hex6, hex5, hex4, a_ovf, b_ovf, busy, update_done}, {28'hFFFFFFF, 4'b0000});
    end
    rst = 1'b0;
    snap = {hex7, hex6, hex5, hex4, a_ovf, b_ovf, busy, update_done};
    changed = 0;
    repeat (10) begin
      @(negedge clk);
      if ({hex7, hex6, hex5, hex4, a_ovf, b_ovf, busy, update_done} !== snap) changed++;
    end
    n_checks++;
    if (changed != 0) begin
      n_fail++;
      $display("FAIL idle_hold got %0d changed cycles required 0", changed);
    end
  endtask

  task automatic test_conversion(input logic [31:0] a, input logic [31:0] b, input string name);
    int bad;
    rf_a_val = a; rf_b_val = b; force_update = 1'b1;
    sb_q.push_back(model(a, b, 1'b1));
    @(negedge clk);
    force_update = 1'b0;
    bad = 0;
    for (int i = 1; i <= 16; i++) begin
      if (i > 1) @(negedge clk);
      if (busy !== 1'b1 || update_done !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s_busy_window got %0d bad cycles required 0", name, bad);
    end
    @(negedge clk);
    n_checks++;
    if (update_done !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_latency got done=%b busy=%b required done=1 busy=0", name, update_done, busy);
    end
    @(negedge clk);
  endtask

  task automatic test_busy_rules();
    int pulses;
    rf_a_val = 32'd23; rf_b_val = 32'd77; force_update = 1'b1;
    sb_q.push_back(model(32'd23, 32'd77, 1'b1));
    @(negedge clk);
    force_update = 1'b0;
    repeat (4) @(negedge clk);
    force_update = 1'b1; rf_a_val = 32'd88;
    @(negedge clk);
    force_update = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (update_done === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 1) begin
      n_fail++;
      $display("FAIL busy_single_update got %0d pulses required 1", pulses);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    rf_a_val = 32'd12; rf_b_val = 32'd34; force_update = 1'b1;
    @(negedge clk);
    force_update = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({hex7, hex6, hex5, hex4, a_ovf, b_ovf, busy, update_done} !== {28'hFFFFFFF, 4'b0000}) begin
      n_fail++;
      $display("FAIL reset_mid_state got %h required %h",
               {hex7, hex6, hex5, hex4, a_ovf, b_ovf, busy, update_done}, {28'hFFFFFFF, 4'b0000});
    end
    pulses = 0;
    repeat (25) begin
      @(negedge clk);
      if (update_done === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 0) begin
      n_fail++;
      $display("FAIL reset_mid_no_update got %0d pulses required 0", pulses);
    end
    test_conversion(32'd12, 32'd34, "after_reset");
  endtask

  task automatic test_auto_refresh();
    exp_t e;
    int found;
    int gap;
    rf_a_val = 32'd63; rf_b_val = 32'd5;
    e = model(32'd63, 32'd5, 1'b0);
    found = 0;
    for (int i = 0; i < 37 && found == 0; i++) begin
      @(negedge clk);
      if (ar_update_done === 1'b1 &&
          {ar_hex7, ar_hex6, ar_hex5, ar_hex4, ar_a_ovf, ar_b_ovf} === e) found = 1;
    end
    n_checks++;
    if (found == 0) begin
      n_fail++;
      $display("FAIL auto_refresh_value got %h required %h within 36 cycles",
               {ar_hex7, ar_hex6, ar_hex5, ar_hex4, ar_a_ovf, ar_b_ovf}, e);
    end
    for (int k = 0; k < 2; k++) begin
      gap = 0;
      do begin
        @(negedge clk);
        gap++;
      end while (ar_update_done !== 1'b1 && gap < 30);
      n_checks++;
      if (gap != 20) begin
        n_fail++;
        $display("FAIL auto_refresh_period got %0d cycles required 20", gap);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_conversion(32'd47, 32'd5, "normal");
    test_conversion(32'd100, 32'hFFFFFFFF, "overflow");
    test_conversion(32'd99, 32'd10, "max_in_range");
    test_conversion(32'd0, 32'd256, "zero_and_wide_ovf");
    test_busy_rules();
    test_reset_mid();
    test_auto_refresh();
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got %0d pending required 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
